// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and tracker state type.
package ps2_pkg;

   localparam logic [7:0] PS2_E0     = 8'hE0;
   localparam logic [7:0] PS2_E1     = 8'hE1;
   localparam logic [7:0] PS2_F0     = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_OVR0   = 8'h00;
   localparam logic [7:0] PS2_OVRF   = 8'hFF;

   localparam logic [7:0] SC_LEFT    = 8'h6B;  // E0-prefixed
   localparam logic [7:0] SC_RIGHT   = 8'h74;  // E0-prefixed
   localparam logic [7:0] SC_JUMP    = 8'h12;
   localparam logic [7:0] SC_SHOOT   = 8'h1A;
   localparam logic [7:0] SC_SUICIDE = 8'h15;
   localparam logic [7:0] SC_RESTART = 8'h2D;

   localparam logic [2:0] KEY_LEFT    = 3'd0;
   localparam logic [2:0] KEY_RIGHT   = 3'd1;
   localparam logic [2:0] KEY_JUMP    = 3'd2;
   localparam logic [2:0] KEY_SHOOT   = 3'd3;
   localparam logic [2:0] KEY_SUICIDE = 3'd4;
   localparam logic [2:0] KEY_RESTART = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0,
      SKIP
   } ps2_state_e;

   // Self-test pass and overrun codes all wipe the held-key state.
   function automatic logic is_wipe_code(input logic [7:0] code);
      return (code == PS2_BAT_OK) || (code == PS2_OVR0) || (code == PS2_OVRF);
   endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Scan-code to key-index lookup; the only place the key map is defined.
module ps2_key_map
   import ps2_pkg::*;
(
   input  logic       extended,
   input  logic [7:0] code,
   output logic       hit,
   output logic [2:0] index
);

   always_comb begin
      hit   = 1'b0;
      index = '0;
      if (extended) begin
         case (code)
            SC_LEFT:  begin hit = 1'b1; index = KEY_LEFT;  end
            SC_RIGHT: begin hit = 1'b1; index = KEY_RIGHT; end
            default:  ;
         endcase
      end else begin
         case (code)
            SC_JUMP:    begin hit = 1'b1; index = KEY_JUMP;    end
            SC_SHOOT:   begin hit = 1'b1; index = KEY_SHOOT;   end
            SC_SUICIDE: begin hit = 1'b1; index = KEY_SUICIDE; end
            SC_RESTART: begin hit = 1'b1; index = KEY_RESTART; end
            default:    ;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 make/break tracker producing a held-key vector.
// Optional KEY_EDGE_EN adds key_press, a one-cycle pulse on each key going 0->1.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [5:0] keys,
   output logic       busy
`ifdef KEY_EDGE_EN
   ,
   output logic [5:0] key_press
`endif
);

   ps2_state_e       state, state_nxt;
   logic [2:0]       skip_cnt, skip_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic [5:0]       keys_nxt;
   logic             byte_ok;
   logic             timeout;
   logic             map_ext;
   logic             map_hit;
   logic [2:0]       map_idx;
   logic             key_set;
   logic             key_clr;
   logic             key_wipe;

   assign byte_ok = rx_valid & ~rx_err;
   assign timeout = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYC));

   ps2_key_map u_key_map (
      .extended (map_ext),
      .code     (rx_data),
      .hit      (map_hit),
      .index    (map_idx)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   // Error beats valid, valid beats timeout; key actions are decoded here
   // and applied by the key register below.
   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      map_ext   = 1'b0;
      key_set   = 1'b0;
      key_clr   = 1'b0;
      key_wipe  = 1'b0;
      if (rx_err) begin
         state_nxt = IDLE;
         skip_nxt  = '0;
      end else if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == PS2_E0) begin
                  state_nxt = GOT_E0;
               end else if (rx_data == PS2_F0) begin
                  state_nxt = GOT_F0;
               end else if (rx_data == PS2_E1) begin
                  state_nxt = SKIP;
                  skip_nxt  = 3'd7;
               end else if (is_wipe_code(rx_data)) begin
                  key_wipe = 1'b1;
               end else begin
                  key_set = 1'b1;
               end
            end
            GOT_E0: begin
               if (rx_data == PS2_F0) begin
                  state_nxt = GOT_E0F0;
               end else if (rx_data != PS2_E0) begin
                  map_ext   = 1'b1;
                  key_set   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            GOT_F0: begin
               if (rx_data == PS2_E0) begin
                  state_nxt = GOT_E0;
               end else if (rx_data != PS2_F0) begin
                  key_clr   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            GOT_E0F0: begin
               map_ext   = 1'b1;
               key_clr   = 1'b1;
               state_nxt = IDLE;
            end
            SKIP: begin
               if (skip_cnt <= 3'd1) begin
                  skip_nxt  = '0;
                  state_nxt = IDLE;
               end else begin
                  skip_nxt = skip_cnt - 3'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
               skip_nxt  = '0;
            end
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
         skip_nxt  = '0;
      end
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         to_cnt <= '0;
      end else if (byte_ok || rx_err || timeout || state == IDLE) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      keys_nxt = keys;
      if (key_wipe) begin
         keys_nxt = '0;
      end else if (map_hit && key_set) begin
         keys_nxt[map_idx] = 1'b1;
      end else if (map_hit && key_clr) begin
         keys_nxt[map_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         keys <= '0;
      end else begin
         keys <= keys_nxt;
      end
   end

`ifdef KEY_EDGE_EN
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         key_press <= '0;
      end else begin
         key_press <= keys_nxt & ~keys;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed plus randomized bench for ps2_key_tracker against a prefix-flag parser model.
module tb_ps2_key_tracker;

   localparam int unsigned T_CYC = 3000;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic [5:0] keys;
   logic       busy;
`ifdef KEY_EDGE_EN
   logic [5:0] key_press;
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: pending prefix flags, skip count, held keys.
   bit       m_ext, m_brk;
   int       m_skip;
   bit [5:0] m_keys, m_prev;

   always #5 clk = ~clk;

   ps2_key_tracker #(.TIMEOUT_CYC(T_CYC)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .keys     (keys),
      .busy     (busy)
`ifdef KEY_EDGE_EN
      ,
      .key_press(key_press)
`endif
   );

   function automatic int key_of(bit ext, logic [7:0] code);
      if (ext) return (code == 8'h6B) ? 0 : (code == 8'h74) ? 1 : -1;
      case (code)
         8'h12:   return 2;
         8'h1A:   return 3;
         8'h15:   return 4;
         8'h2D:   return 5;
         default: return -1;
      endcase
   endfunction

   function automatic void m_abort();
      m_ext = 0; m_brk = 0; m_skip = 0;
   endfunction

   function automatic void m_complete(logic [7:0] b);
      int k;
      k = key_of(m_ext, b);
      if (k >= 0) m_keys[k] = !m_brk;
      m_ext = 0; m_brk = 0;
   endfunction

   function automatic void m_byte(logic [7:0] b);
      m_prev = m_keys;
      if (m_skip > 0) m_skip--;
      else if (m_ext && m_brk) m_complete(b);
      else if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else if (!m_ext && !m_brk && b == 8'hE1) m_skip = 7;
      else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'h00 || b == 8'hFF)) m_keys = '0;
      else m_complete(b);
   endfunction

   task automatic chk(input string tag);
      bit exp_busy;
      exp_busy = m_ext || m_brk || (m_skip > 0);
      total++;
      assert (keys === m_keys) passed++;
      else $error("FAIL %s keys: observed %b expected %b", tag, keys, m_keys);
      total++;
      assert (busy === exp_busy) passed++;
      else $error("FAIL %s busy: observed %b expected %b", tag, busy, exp_busy);
`ifdef KEY_EDGE_EN
      total++;
      assert (key_press === (m_keys & ~m_prev)) passed++;
      else $error("FAIL %s key_press: observed %b expected %b", tag, key_press, m_keys & ~m_prev);
`endif
   endtask

   task automatic send(input logic [7:0] b, input bit err = 0);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1; rx_err = err;
      @(negedge clk);
      rx_valid = 1'b0; rx_err = 1'b0;
      if (err) begin m_prev = m_keys; m_abort(); end
      else m_byte(b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      m_prev = m_keys;
   endtask

   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h1A, 8'h15,
                              8'h2D, 8'h6B, 8'h74, 8'hAA, 8'h00, 8'hFF};

   initial begin
      logic [7:0] b;
      bit e;
      m_abort(); m_keys = '0; m_prev = '0;
      idle(3);
      chk("reset");
      clrn = 1'b1;
      idle(2);
      chk("post_reset");

      // jump make, then break with a long gap inside the break sequence
      send(8'h12);  chk("jump_make");
      idle(2000);   chk("jump_held");
      send(8'hF0);  chk("jump_f0");
      idle(2000);   chk("jump_f0_wait");
      send(8'h12);  chk("jump_break");

      // extended left vs keypad 4
      send(8'hE0); chk("left_e0");
      send(8'h6B); chk("left_make");
      send(8'h6B); chk("kp4_plain");
      send(8'hE0); send(8'hF0); chk("left_e0f0");
      send(8'h6B); chk("left_break");

      // two held keys wiped by self-test pass
      send(8'h2D); send(8'h1A); chk("two_held");
      send(8'hAA); chk("bat_wipe");

      // Pause make sequence is swallowed whole
      send(8'hE1); chk("pause_1");
      send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
      chk("pause_7");
      send(8'h77); chk("pause_8");
      send(8'h15); chk("suicide_make");

      // stalled E0 times out; following 74 is non-extended
      send(8'hE0);
      idle(T_CYC - 5); chk("stall_busy");
      idle(10); m_abort(); chk("stall_timeout");
      send(8'h74); chk("right_plain");

      // error drops the coinciding byte
      send(8'hF0, 1); chk("err_drop");
      send(8'h1A);    chk("shoot_make");

      // async reset mid-sequence
      send(8'hE0); chk("pre_reset_seq");
      #2 clrn = 1'b0;
      #1 m_abort(); m_keys = '0; m_prev = '0; chk("async_reset");
      idle(2);
      clrn = 1'b1;
      idle(1);

      // randomized byte stream, occasional receive errors
      for (int i = 0; i < 400; i++) begin
         b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
         e = ($urandom_range(0, 24) == 0);
         send(b, e);
         chk($sformatf("rand%0d_%h", i, b));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver and the renderer.
- Consumes decoded PS/2 set-2 scan-code bytes and tracks make/break sequences, including the E0 extended and F0 break prefixes.
- Maintains a registered 6-bit held-key vector: bits [4:0] drive game control, bit [5] drives the restart path.
- Also handles the Pause (E1) sequence, keyboard self-test and overrun codes, receive errors, and stalled sequences.

Parameters:
- TIMEOUT_CYC, 500000: clk cycles allowed between bytes of one multi-byte sequence before it is abandoned (5 ms at 100 MHz).
- CNT_W, $clog2(TIMEOUT_CYC+1): width of the timeout counter.

Ports:
- clk  input  1  system clock.
- clrn  input  1  asynchronous active-low reset.
- rx_data  input  8  received scan-code byte; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
- rx_err  input  1  one-cycle strobe: parity or framing error on the current frame.
- keys  output  6  held state: [0] left, [1] right, [2] jump, [3] shoot, [4] suicide, [5] restart.
- busy  output  1  1 while a multi-byte sequence is in progress (state != IDLE).

Behaviour:
- Reset (clrn=0, asynchronous): keys=6'b0, state=IDLE, timeout counter=0, skip counter=0, busy=0.
- Key map (set 2):
  - left = E0 6B
  - right = E0 74
  - jump = 12 (L-Shift)
  - shoot = 1A (Z)
  - suicide = 15 (Q)
  - restart = 2D (R)
  - All other codes are ignored; unmapped bytes change no key bit.
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP.
- Transitions on rx_valid=1 with rx_err=0:
  - IDLE:
    - E0 -> GOT_E0.
    - F0 -> GOT_F0.
    - E1 -> SKIP, skip counter=7.
    - AA, 00 or FF -> keys cleared, stay in IDLE.
    - Any other byte: non-extended make; set the mapped bit, stay in IDLE.
  - GOT_E0:
    - F0 -> GOT_E0F0.
    - E0 -> stay in GOT_E0.
    - Any other byte: extended make; set the mapped bit, -> IDLE.
  - GOT_F0:
    - F0 -> stay in GOT_F0.
    - E0 -> GOT_E0; the pending break is discarded.
    - Any other byte: non-extended break; clear the mapped bit, -> IDLE.
  - GOT_E0F0:
    - Any byte: extended break; clear the mapped bit, -> IDLE.
  - SKIP:
    - Decrement the skip counter on each byte; -> IDLE when it reaches 0 (the 8-byte Pause make sequence is discarded whole).
- Extended and non-extended codes are distinct: a plain 6B (keypad 4) does not set left.
- Latency: keys updates on the clock edge that samples the final byte, so it is visible the cycle after the rx_valid strobe.
- Timeout:
  - The counter runs while state != IDLE and resets to 0 on every accepted byte.
  - When the counter reaches TIMEOUT_CYC: -> IDLE, keys unchanged.
  - If rx_valid arrives in the same cycle as the timeout, the byte is processed normally; valid wins.
- Error: rx_err=1 -> IDLE and skip counter=0; keys unchanged. If rx_err and rx_valid coincide, the error wins and the byte is dropped.
- Repeated makes (typematic) re-set an already-set bit; no effect.
- Simultaneously held keys are independent bits.
- busy is combinational from state.

Optional Feature:
- Macro: KEY_EDGE_EN.
- When defined: adds output key_press [5:0], a registered one-cycle pulse on each 0->1 transition of a keys bit. The pulse is asserted in the same cycle the bit first reads 1. Typematic repeats and clears give no pulse. Reset value is 0.
- When undefined: the port and its logic are absent; keys behaviour is identical.

Decomposition:
- Shared package ps2_pkg holds:
  - Byte constants: PS2_E0, PS2_E1, PS2_F0, PS2_BAT_OK (AA), PS2_OVR0 (00), PS2_OVRF (FF).
  - Scan-code constants for the six mapped keys.
  - Key-index constants: KEY_LEFT=0, KEY_RIGHT=1, KEY_JUMP=2, KEY_SHOOT=3, KEY_SUICIDE=4, KEY_RESTART=5.
  - The state enum typedef.
- One combinational sub-module, ps2_key_map: inputs {extended, code}, outputs {hit, index[2:0]}; it is the only place the key map lives.
- The FSM, counters and key register stay in the parent.

Test Plan:
- Bytes 12, then F0 12, spaced 2000 cycles apart -> keys[2]=1 the cycle after the first strobe, 0 the cycle after the 12 following F0; busy=1 only between F0 and the final 12.
- E0 6B, then 6B, then E0 F0 6B -> keys[0]=1 after the first sequence, unchanged by the plain 6B, 0 after the break.
- Hold 2D and 1A together, send AA -> keys=6'b101000, then 6'b000000 the cycle after AA.
- E1 14 77 E1 F0 14 F0 77, then 15 -> keys unchanged through the Pause sequence; keys[4]=1 after 15; busy=0 after the 8th byte.
- E0, idle TIMEOUT_CYC cycles, then 74 -> state returns to IDLE at timeout; 74 is treated as non-extended, so keys[1] stays 0.
- F0 with rx_err=1 in the same cycle, then 1A -> F0 dropped, keys[3]=1; clrn pulsed low mid-sequence -> keys=0, busy=0 immediately.
